// File: rtl/way_line_select.sv
// -----------------------------------------------------------------------------
// way_line_select
//   Picks one cache line out of NUM_WAYS candidate lines (lowest-index set bit
//   of i_sel wins), extracts one WORD_BYTES-wide word from it, and presents
//   both through a valid/ready output stage.
//   The output stage is a registered main slot plus a one-entry skid slot.
//   o_ready is registered, so there is no combinational path from i_ready.
//
//   Optional feature (macro WAY_SEL_ONEHOT_CHECK_EN):
//     When defined, o_err flags requests whose i_sel has more than one bit
//     set, and o_err_cnt counts such accepts, saturating at 255.
//     When undefined, o_err and o_err_cnt are tied to zero.
//
// Ports
//   i_clk       clock
//   i_rst       synchronous active-high reset
//   i_data      NUM_WAYS flattened lines, way w at [w*L +: L]
//   i_sel       way select (one-hot expected)
//   i_word_off  word index inside the selected line
//   i_valid     upstream request valid
//   o_ready     upstream may present (registered)
//   o_line      selected line
//   o_word      selected word
//   o_hit       i_sel was nonzero
//   o_valid     output valid
//   i_ready     downstream accepts
//   o_err       request was not one-hot (checker build only)
//   o_err_cnt   saturating count of non-one-hot accepts (checker build only)
// -----------------------------------------------------------------------------
module way_line_select #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int NUM_WAYS        = 4,
  parameter int WORD_BYTES      = 8,
  localparam int L              = LINE_SIZE_BYTES * 8,
  localparam int WW             = WORD_BYTES * 8,
  localparam int NUM_WORDS      = LINE_SIZE_BYTES / WORD_BYTES,
  localparam int OFF_W          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_WAYS*L-1:0] i_data,
  input  logic [NUM_WAYS-1:0]   i_sel,
  input  logic [OFF_W-1:0]      i_word_off,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [L-1:0]          o_line,
  output logic [WW-1:0]         o_word,
  output logic                  o_hit,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_err,
  output logic [7:0]            o_err_cnt
);

  // Request payload derived from the current inputs
  logic [L-1:0]  req_line_s;
  logic [WW-1:0] req_word_s;
  logic          req_hit_s;

  // Handshake decode
  logic accept_s;
  logic main_load_s;

  // Main slot (drives all outputs) and skid slot
  logic          main_valid_q, main_valid_d;
  logic [L-1:0]  main_line_q,  main_line_d;
  logic [WW-1:0] main_word_q,  main_word_d;
  logic          main_hit_q,   main_hit_d;
  logic          skid_valid_q, skid_valid_d;
  logic [L-1:0]  skid_line_q,  skid_line_d;
  logic [WW-1:0] skid_word_q,  skid_word_d;
  logic          skid_hit_q,   skid_hit_d;
  logic          ready_q,      ready_d;

  assign accept_s    = i_valid && ready_q;
  // Main slot can take new contents when it is empty or being drained
  assign main_load_s = !main_valid_q || i_ready;
  assign req_hit_s   = |i_sel;

  // Way mux: scanning downward lets the lowest set index overwrite last
  always_comb begin
    req_line_s = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (i_sel[w]) begin
        req_line_s = i_data[w*L +: L];
      end else begin
        req_line_s = req_line_s;
      end
    end
  end

  // Word extraction from the selected line
  always_comb begin
    req_word_s = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (i_word_off == OFF_W'(k)) begin
        req_word_s = req_line_s[k*WW +: WW];
      end else begin
        req_word_s = req_word_s;
      end
    end
  end

  // Slot next-state: skid drains into main first; otherwise a new accept
  // goes to main when it is free, or to skid when main is stalled
  always_comb begin
    main_valid_d = main_valid_q;
    main_line_d  = main_line_q;
    main_word_d  = main_word_q;
    main_hit_d   = main_hit_q;
    skid_valid_d = skid_valid_q;
    skid_line_d  = skid_line_q;
    skid_word_d  = skid_word_q;
    skid_hit_d   = skid_hit_q;
    if (main_load_s) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_line_d  = skid_line_q;
        main_word_d  = skid_word_q;
        main_hit_d   = skid_hit_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        main_valid_d = 1'b1;
        main_line_d  = req_line_s;
        main_word_d  = req_word_s;
        main_hit_d   = req_hit_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_d = 1'b1;
        skid_line_d  = req_line_s;
        skid_word_d  = req_word_s;
        skid_hit_d   = req_hit_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    ready_d = !skid_valid_d;
  end

  // Slot registers; reset empties both slots and clears the payload
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_valid_q <= 1'b0;
      main_line_q  <= '0;
      main_word_q  <= '0;
      main_hit_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_line_q  <= '0;
      skid_word_q  <= '0;
      skid_hit_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_line_q  <= main_line_d;
      main_word_q  <= main_word_d;
      main_hit_q   <= main_hit_d;
      skid_valid_q <= skid_valid_d;
      skid_line_q  <= skid_line_d;
      skid_word_q  <= skid_word_d;
      skid_hit_q   <= skid_hit_d;
      ready_q      <= ready_d;
    end
  end

  assign o_valid = main_valid_q;
  assign o_line  = main_line_q;
  assign o_word  = main_word_q;
  assign o_hit   = main_hit_q;
  assign o_ready = ready_q;

`ifdef WAY_SEL_ONEHOT_CHECK_EN
  // True when more than one select bit is set
  function automatic logic multi_hot(input logic [NUM_WAYS-1:0] v);
    return (v & (v - NUM_WAYS'(1))) != '0;
  endfunction

  logic       req_err_s;
  logic       main_err_q, main_err_d;
  logic       skid_err_q, skid_err_d;
  logic [7:0] err_cnt_q,  err_cnt_d;

  assign req_err_s = multi_hot(i_sel);

  // Error flag follows its request through the same slot moves
  always_comb begin
    main_err_d = main_err_q;
    skid_err_d = skid_err_q;
    if (main_load_s) begin
      if (skid_valid_q) begin
        main_err_d = skid_err_q;
      end else if (accept_s) begin
        main_err_d = req_err_s;
      end else begin
        main_err_d = main_err_q;
      end
    end else begin
      if (accept_s) begin
        skid_err_d = req_err_s;
      end else begin
        skid_err_d = skid_err_q;
      end
    end
  end

  // Saturating count of accepted non-one-hot requests
  always_comb begin
    if (accept_s && req_err_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Checker registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_err_q <= 1'b0;
      skid_err_q <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      main_err_q <= main_err_d;
      skid_err_q <= skid_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_err     = main_err_q;
  assign o_err_cnt = err_cnt_q;
`else
  assign o_err     = 1'b0;
  assign o_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_way_line_select.sv
module tb_way_line_select;

`ifdef WAY_SEL_ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-way, 64-byte-line instance
  logic          rst;
  logic [2047:0] data;
  logic [3:0]    sel;
  logic [2:0]    off;
  logic          valid, ready;
  logic          o_ready, o_hit, o_valid, o_err;
  logic [511:0]  o_line;
  logic [63:0]   o_word;
  logic [7:0]    o_err_cnt;

  way_line_select dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_sel(sel), .i_word_off(off),
    .i_valid(valid), .o_ready(o_ready), .o_line(o_line), .o_word(o_word),
    .o_hit(o_hit), .o_valid(o_valid), .i_ready(ready), .o_err(o_err),
    .o_err_cnt(o_err_cnt)
  );

  // 8-way, 32-byte-line instance
  logic [2047:0] data8;
  logic [7:0]    sel8;
  logic [1:0]    off8;
  logic          valid8, ready8;
  logic          o_ready8, o_hit8, o_valid8, o_err8;
  logic [255:0]  o_line8;
  logic [63:0]   o_word8;
  logic [7:0]    o_err_cnt8;

  way_line_select #(.LINE_SIZE_BYTES(32), .NUM_WAYS(8), .WORD_BYTES(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_data(data8), .i_sel(sel8), .i_word_off(off8),
    .i_valid(valid8), .o_ready(o_ready8), .o_line(o_line8), .o_word(o_word8),
    .o_hit(o_hit8), .o_valid(o_valid8), .i_ready(ready8), .o_err(o_err8),
    .o_err_cnt(o_err_cnt8)
  );

  typedef struct {
    logic [511:0] line;
    logic [63:0]  word;
    logic         hit;
    logic         err;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [2:0] off;
    logic [7:0] fill;
    logic       hit;
    logic       multi;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic m_ready;
  int   m_cnt;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic chk_line(input string n, input logic [511:0] a, input logic [511:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  // Reference: isolate lowest set bit arithmetically, then slice bytes
  function automatic exp_t model(input logic [2047:0] d, input logic [3:0] s,
                                 input logic [2:0] o);
    exp_t       e;
    logic [3:0] low;
    int         way;
    low   = s & (~s + 4'd1);
    way   = 0;
    for (int w = 0; w < 4; w++) if (low == (4'd1 << w)) way = w;
    e.hit  = (s != 4'd0);
    e.line = e.hit ? d[way*512 +: 512] : 512'd0;
    e.word = e.line[o*64 +: 64];
    e.err  = CHK ? (s != low) : 1'b0;
    return e;
  endfunction

  function automatic logic [2047:0] rand_data();
    logic [2047:0] x;
    for (int i = 0; i < 64; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  function automatic logic [2047:0] fill_data();
    logic [2047:0] x;
    for (int w = 0; w < 4; w++) x[w*512 +: 512] = {64{8'h10 + 8'(w)}};
    return x;
  endfunction

  // Called at a negedge: check outputs against the model, drive, advance one cycle
  task automatic step(input logic v, input logic [3:0] s, input logic [2:0] o,
                      input logic [2047:0] d, input logic r, input logic rs);
    exp_t e;
    logic acc;
    chk("o_valid", 64'(o_valid), 64'(q.size() > 0));
    chk("o_ready", 64'(o_ready), 64'(m_ready));
    chk("o_err_cnt", 64'(o_err_cnt), 64'(m_cnt));
    if (q.size() > 0) begin
      chk_line("o_line", o_line, q[0].line);
      chk("o_word", o_word, q[0].word);
      chk("o_hit", 64'(o_hit), 64'(q[0].hit));
      chk("o_err", 64'(o_err), 64'(q[0].err));
    end
    valid = v; sel = s; off = o; data = d; ready = r; rst = rs;
    if (rs) begin
      q.delete();
      m_ready = 1'b0;
      m_cnt   = 0;
    end else begin
      acc = v && m_ready;
      e   = model(d, s, o);
      if (r && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.err && m_cnt < 255) m_cnt++;
      end
      m_ready = (q.size() < 2);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[6];
    logic [2047:0] fd;
    logic [3:0]    rs_sel;
    int            n_xfer;

    tbl[0] = '{sel: 4'b0100, off: 3'd3, fill: 8'h12, hit: 1'b1, multi: 1'b0};
    tbl[1] = '{sel: 4'b0000, off: 3'd0, fill: 8'h00, hit: 1'b0, multi: 1'b0};
    tbl[2] = '{sel: 4'b0001, off: 3'd7, fill: 8'h10, hit: 1'b1, multi: 1'b0};
    tbl[3] = '{sel: 4'b1000, off: 3'd0, fill: 8'h13, hit: 1'b1, multi: 1'b0};
    tbl[4] = '{sel: 4'b0110, off: 3'd5, fill: 8'h11, hit: 1'b1, multi: 1'b1};
    tbl[5] = '{sel: 4'b1111, off: 3'd2, fill: 8'h10, hit: 1'b1, multi: 1'b1};

    rst = 1'b1; valid = 1'b0; ready = 1'b0; sel = 4'd0; off = 3'd0; data = '0;
    valid8 = 1'b0; ready8 = 1'b0; sel8 = 8'd0; off8 = 2'd0; data8 = '0;
    m_ready = 1'b0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);

    // Release reset; o_ready must rise on the first cycle after
    step(1'b0, 4'd0, 3'd0, '0, 1'b0, 1'b0);
    chk("post_rst_ready", 64'(o_ready), 64'd1);
    chk_line("post_rst_line", o_line, 512'd0);
    chk("post_rst_word", o_word, 64'd0);
    chk("post_rst_hit", 64'(o_hit), 64'd0);
    chk("post_rst_err", 64'(o_err), 64'd0);
    chk("post_rst_cnt", 64'(o_err_cnt), 64'd0);

    // Directed vectors with one-byte-per-way fill
    fd = fill_data();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tbl[i].sel, tbl[i].off, fd, 1'b1, 1'b0);
      chk("tbl_valid", 64'(o_valid), 64'd1);
      chk_line("tbl_line", o_line, {64{tbl[i].fill}});
      chk("tbl_word", o_word, {8{tbl[i].fill}});
      chk("tbl_hit", 64'(o_hit), 64'(tbl[i].hit));
      chk("tbl_err", 64'(o_err), 64'(CHK && tbl[i].multi));
      step(1'b0, 4'd0, 3'd0, fd, 1'b1, 1'b0);
    end

    // A,B,C back to back with downstream stalled for cycles 2-4
    step(1'b1, 4'b0001, 3'd1, rand_data(), 1'b1, 1'b0);
    step(1'b1, 4'b0010, 3'd2, rand_data(), 1'b0, 1'b0);
    chk("stall_ready", 64'(o_ready), 64'd0);
    fd = rand_data();
    step(1'b1, 4'b0100, 3'd3, fd, 1'b0, 1'b0);
    chk("stall_ready2", 64'(o_ready), 64'd0);
    step(1'b1, 4'b0100, 3'd3, fd, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 3'd3, fd, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 3'd3, fd, 1'b1, 1'b0);
    step(1'b0, 4'd0, 3'd0, fd, 1'b1, 1'b0);
    step(1'b0, 4'd0, 3'd0, fd, 1'b1, 1'b0);
    chk("abc_drained", 64'(o_valid), 64'd0);

    // Non-one-hot select repeated until the counter saturates
    for (int i = 0; i < 300; i++) step(1'b1, 4'b0110, 3'(i), fd, 1'b1, 1'b0);
    step(1'b0, 4'd0, 3'd0, fd, 1'b1, 1'b0);
    chk("err_sat", 64'(o_err_cnt), CHK ? 64'd255 : 64'd0);

    // Reset with both slots occupied
    step(1'b1, 4'b0001, 3'd0, rand_data(), 1'b0, 1'b0);
    step(1'b1, 4'b1000, 3'd4, rand_data(), 1'b0, 1'b0);
    step(1'b1, 4'b0010, 3'd0, rand_data(), 1'b1, 1'b1);
    chk("rst_full_valid", 64'(o_valid), 64'd0);
    chk("rst_full_ready", 64'(o_ready), 64'd0);
    step(1'b0, 4'd0, 3'd0, '0, 1'b1, 1'b0);
    chk("rst_full_ready_after", 64'(o_ready), 64'd1);
    chk("rst_full_valid_after", 64'(o_valid), 64'd0);
    chk("rst_full_cnt", 64'(o_err_cnt), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) rs_sel = 4'($urandom);
      else rs_sel = 4'd1 << $urandom_range(0, 3);
      step(1'($urandom_range(0, 3) != 0), rs_sel, 3'($urandom), rand_data(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
    end
    step(1'b0, 4'd0, 3'd0, '0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 3'd0, '0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 3'd0, '0, 1'b1, 1'b0);

    // 8-way instance: ten back-to-back accepts on way 7, one transfer per cycle
    chk("w8_ready", 64'(o_ready8), 64'd1);
    n_xfer = 0;
    ready8 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      data8 = rand_data();
      data8[7*256 +: 256] = {32{8'(k)}};
      sel8 = 8'h80; off8 = 2'(k); valid8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("w8_valid", 64'(o_valid8), 64'd1);
      chk("w8_hit", 64'(o_hit8), 64'd1);
      chk_line("w8_line", 512'(o_line8), 512'({32{8'(k)}}));
      chk("w8_word", o_word8, {8{8'(k)}});
      if (o_valid8 && ready8) n_xfer++;
    end
    valid8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w8_xfers", 64'(n_xfer), 64'd10);
    chk("w8_idle", 64'(o_valid8), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
